instruction_fetch_unit: RTL



---
 rtl/ifu_pkg.sv | 16 +
 rtl/instruction_fetch_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int XLEN = 32;

  // Canonical addi x0,x0,0 for inserting bubbles downstream.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetch PC owner and IF/ID writer; one outstanding imem request at a time.
// Optional perf counters are enabled by defining IFU_PERF_CNT_EN.
//
// state  | meaning
// S_IDLE | ready to issue a request at fetch_pc
// S_WAIT | request outstanding, response will be captured
// S_HOLD | fetched word presented on if_*, waiting for id_ready
// S_DROP | redirected while a request was outstanding; discard its response
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instruction,
  input  logic            id_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q;
  logic            capture;
  logic            transfer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect always wins over a response or a transfer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!redirect_valid) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid)   state_d = imem_rvalid ? S_IDLE : S_DROP;
        else if (imem_rvalid) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (redirect_valid) state_d = S_IDLE;
        else if (id_ready)  state_d = S_WAIT;
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    if_valid = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      S_IDLE: imem_req = !redirect_valid;
      S_WAIT: capture  = imem_rvalid && !redirect_valid;
      S_HOLD: begin
        if_valid = 1'b1;
        imem_req = id_ready && !redirect_valid;
      end
      default: ;
    endcase
    // The state register already reads S_IDLE under reset, but the request
    // must not leak out combinationally while reset is held.
    if (!reset) imem_req = 1'b0;
  end

  assign transfer  = if_valid && id_ready && !redirect_valid;
  assign imem_addr = fetch_pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q     <= RESET_PC;
      if_pc          <= '0;
      if_instruction <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc;
      end else if (capture) begin
        fetch_pc_q <= fetch_pc_q + STEP;
      end
      if (capture) begin
        if_pc          <= fetch_pc_q;
        if_instruction <= imem_rdata;
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (transfer)              perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (if_valid && !id_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
